// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: operation encodings, FSM states, op classification.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_SLL   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SLT   = 4'b0110;
  localparam logic [3:0] OP_XNOR  = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MULLO = 4'b1010;
  localparam logic [3:0] OP_MULHU = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REMU  = 4'b1101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MULLO) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// WIDTH-step engine: shift-add multiply ({hi,lo} = a*b) or restoring divide (lo = a/b, hi = a%b).
// lo/hi are the values after the current step, so the caller can capture them on the final step.
module alu_muldiv_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] hiReg, loReg, opnd;
  logic             isDiv;
  logic [SHW:0]     cnt;
  logic [WIDTH:0]   sum, shl, diff;

  always_comb begin
    sum  = {1'b0, hiReg} + (loReg[0] ? {1'b0, opnd} : '0);
    shl  = {hiReg, loReg[WIDTH-1]};
    diff = shl - {1'b0, opnd};
    if (isDiv) begin
      // diff[WIDTH] set means the trial subtract borrowed: restore
      if (!diff[WIDTH]) begin
        hi = diff[WIDTH-1:0];
        lo = {loReg[WIDTH-2:0], 1'b1};
      end else begin
        hi = shl[WIDTH-1:0];
        lo = {loReg[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi = sum[WIDTH:1];
      lo = {sum[0], loReg[WIDTH-1:1]};
    end
  end

  assign done = (cnt == (SHW+1)'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hiReg <= '0;
      loReg <= '0;
      opnd  <= '0;
      isDiv <= 1'b0;
      cnt   <= '0;
    end else if (start) begin
      isDiv <= (op == OP_DIVU) || (op == OP_REMU);
      hiReg <= '0;
      loReg <= ((op == OP_DIVU) || (op == OP_REMU)) ? a : b;
      opnd  <= ((op == OP_DIVU) || (op == OP_REMU)) ? b : a;
      cnt   <= (SHW+1)'(WIDTH);
    end else if (step && cnt != '0) begin
      hiReg <= hi;
      loReg <= lo;
      cnt   <= cnt - (SHW+1)'(1);
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU with registered result; iterative mul/div
// datapath is built only when ALU_SEQ_MULDIV_EN is defined.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ReadData1,
  input  logic [WIDTH-1:0] ReadData2,
  input  logic [WIDTH-1:0] Ext,
  input  logic [WIDTH-1:0] Sa,
  input  logic             ALUSrcA,
  input  logic             ALUSrcB,
  input  logic [3:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             zero,
  output logic             busy
);
  state_t           state;
  logic [WIDTH-1:0] inA, inB, aluRes;
  logic [SHW-1:0]   sh;

  assign inA = ALUSrcA ? Sa  : ReadData1;
  assign inB = ALUSrcB ? Ext : ReadData2;
  assign sh  = inA[SHW-1:0];

  // Mul/div encodings fall to the default here, giving 0 when the engine is absent
  always_comb begin
    aluRes = '0;
    case (ALUop)
      OP_ADD:  aluRes = inA + inB;
      OP_SUB:  aluRes = inA - inB;
      OP_SLL:  aluRes = inB << sh;
      OP_OR:   aluRes = inA | inB;
      OP_AND:  aluRes = inA & inB;
      OP_SLTU: aluRes = {{(WIDTH-1){1'b0}}, inA < inB};
      OP_SLT:  aluRes = {{(WIDTH-1){1'b0}}, $signed(inA) < $signed(inB)};
      OP_XNOR: aluRes = ~(inA ^ inB);
      OP_SRL:  aluRes = inB >> sh;
      OP_SRA:  aluRes = $signed(inB) >>> sh;
      default: aluRes = '0;
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  logic             mdStart, mdDone, selHi;
  logic [WIDTH-1:0] mdLo, mdHi, mdRes;

  assign mdStart = (state == IDLE) && in_valid && is_multicycle(ALUop);
  assign mdRes   = selHi ? mdHi : mdLo;

  alu_muldiv_iter #(.WIDTH(WIDTH)) uIter (
    .clk   (CLK),
    .rst   (Reset),
    .start (mdStart),
    .step  (state == BUSY),
    .op    (ALUop),
    .a     (inA),
    .b     (inB),
    .done  (mdDone),
    .lo    (mdLo),
    .hi    (mdHi)
  );
`endif

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= IDLE;
      Result    <= '0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
`ifdef ALU_SEQ_MULDIV_EN
      selHi     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_ready <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
          if (is_multicycle(ALUop)) begin
            selHi <= ALUop[0];  // MULHU/REMU take the high half
            busy  <= 1'b1;
            state <= BUSY;
          end else begin
            Result    <= aluRes;
            zero      <= (aluRes == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end
`else
          Result    <= aluRes;
          zero      <= (aluRes == '0);
          out_valid <= 1'b1;
          state     <= DONE;
`endif
        end
        BUSY: begin
`ifdef ALU_SEQ_MULDIV_EN
          if (mdDone) begin
            Result    <= mdRes;
            zero      <= (mdRes == '0);
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
`else
          busy  <= 1'b0;
          state <= IDLE;
`endif
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
